// File: rtl/lsu_store_wr_pkg.sv
// lsu_store_wr_pkg: shared LSU store-path types, width encodings and AXI response codes.
package lsu_store_wr_pkg;
    localparam int ADDR = 32;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        RV_LSU_B = 2'd0,
        RV_LSU_H = 2'd1,
        RV_LSU_W = 2'd2
    } rv_lsu_width_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDR_DATA,
        WAIT_RESP
    } st_fsm_t;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    typedef struct packed {
        logic [ADDR-1:0] addr;
        logic [XLEN-1:0] data;
        logic [1:0]      width;
    } s_store_req_t;
endpackage

// File: rtl/lsu_store_wr_store_fmt.sv
// store_fmt: replicates rs2 into byte lanes, builds write strobes and flags misalignment.
module store_fmt
    import lsu_store_wr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SW         = DATA_WIDTH / 8,
    parameter int OW         = $clog2(SW)
) (
    input  logic [OW-1:0]         i_ofs,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_width,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [SW-1:0]         o_wstrb,
    output logic                  o_misaligned
);
    logic w_is_b;
    logic w_is_h;

    // Unknown width encodings fall through to full-word behaviour.
    always_comb begin
        w_is_b       = i_width == RV_LSU_B;
        w_is_h       = i_width == RV_LSU_H;
        o_wdata      = w_is_b ? {SW{i_data[7:0]}} : w_is_h ? {(SW/2){i_data[15:0]}} : i_data;
        o_wstrb      = w_is_b ? SW'(1) << i_ofs : w_is_h ? SW'(3) << i_ofs : '1;
        o_misaligned = w_is_h ? i_ofs[0] : (!w_is_b && i_ofs[1:0] != 2'd0);
    end
endmodule

// File: rtl/lsu_store_wr.sv
// lsu_store_wr: single-outstanding AXI4-Lite store writer with misalign/bus-error reporting.
module lsu_store_wr
    import lsu_store_wr_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_valid_i,
    input  logic [ADDR_WIDTH-1:0]   st_addr_i,
    input  logic [DATA_WIDTH-1:0]   st_data_i,
    input  logic [1:0]              st_width_i,
    output logic                    st_ready_o,
    output logic                    bp_o,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    input  logic [1:0]              bresp_i,
    input  logic                    bvalid_i,
    output logic                    bready_o,
    output logic                    st_err_o,
    output logic                    st_err_typ_o,
    output logic [ADDR_WIDTH-1:0]   st_err_addr_o
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int OW = $clog2(SW);

    st_fsm_t               r_state;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [SW-1:0]         r_wstrb;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_err;
    logic                  r_err_typ;
    logic [ADDR_WIDTH-1:0] r_err_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [SW-1:0]         w_wstrb;
    logic                  w_mis;
    logic                  w_aw_ok;
    logic                  w_w_ok;
    logic                  w_berr;

    store_fmt #(.DATA_WIDTH(DATA_WIDTH)) u_fmt (
        .i_ofs        (st_addr_i[OW-1:0]),
        .i_data       (st_data_i),
        .i_width      (st_width_i),
        .o_wdata      (w_wdata),
        .o_wstrb      (w_wstrb),
        .o_misaligned (w_mis)
    );

    // A channel counts as done once its valid has dropped or is handshaking now.
    assign w_aw_ok = !r_awvalid || awready_i;
    assign w_w_ok  = !r_wvalid || wready_i;
    assign w_berr  = bresp_i == AXI_SLVERR || bresp_i == AXI_DECERR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_err      <= 1'b0;
            r_err_typ  <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: if (st_valid_i) begin
                    if (w_mis) begin
                        r_err      <= 1'b1;
                        r_err_typ  <= 1'b0;
                        r_err_addr <= st_addr_i;
                    end else begin
                        r_awaddr  <= st_addr_i;
                        r_wdata   <= w_wdata;
                        r_wstrb   <= w_wstrb;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= ADDR_DATA;
                    end
                end
                ADDR_DATA: begin
                    if (awready_i) r_awvalid <= 1'b0;
                    if (wready_i) r_wvalid <= 1'b0;
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                        r_state  <= WAIT_RESP;
                    end
                end
                WAIT_RESP: if (bvalid_i) begin
                    r_bready <= 1'b0;
                    r_state  <= IDLE;
                    if (w_berr) begin
                        r_err      <= 1'b1;
                        r_err_typ  <= 1'b1;
                        r_err_addr <= r_awaddr;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign st_ready_o    = r_state == IDLE;
    assign bp_o          = r_state != IDLE;
    assign awaddr_o      = r_awaddr;
    assign awvalid_o     = r_awvalid;
    assign wdata_o       = r_wdata;
    assign wstrb_o       = r_wstrb;
    assign wvalid_o      = r_wvalid;
    assign bready_o      = r_bready;
    assign st_err_o      = r_err;
    assign st_err_typ_o  = r_err_typ;
    assign st_err_addr_o = r_err_addr;
endmodule

// File: tb/tb_lsu_store_wr.sv
// tb_lsu_store_wr: randomized store traffic against a transaction-level model of the writer.
module tb_lsu_store_wr;
    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_width;
    logic        st_ready_o;
    logic        bp_o;
    logic [31:0] awaddr_o;
    logic        awvalid_o;
    logic        awready;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        wvalid_o;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready_o;
    logic        st_err_o;
    logic        st_err_typ_o;
    logic [31:0] st_err_addr_o;
    int          total = 0;
    int          bad = 0;

    lsu_store_wr dut (
        .clk(clk), .rst(rst),
        .st_valid_i(st_valid), .st_addr_i(st_addr), .st_data_i(st_data), .st_width_i(st_width),
        .st_ready_o(st_ready_o), .bp_o(bp_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready),
        .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready_o),
        .st_err_o(st_err_o), .st_err_typ_o(st_err_typ_o), .st_err_addr_o(st_err_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int size_of(input logic [1:0] w);
        return w == 2'd0 ? 1 : w == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] d, input int sz);
        return sz == 1 ? (d & 32'hFF) * 32'h01010101 : sz == 2 ? (d & 32'hFFFF) * 32'h00010001 : d;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [31:0] a, input int sz);
        int m;
        m = ((1 << sz) - 1) << (a % 4);
        return m[3:0];
    endfunction

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                            input int awd, input int wd, input int bd, input logic [1:0] resp);
        int          sz;
        bit          aw_done;
        bit          w_done;
        bit          hs_aw;
        bit          hs_w;
        int          cyc;
        logic [31:0] ed;
        logic [3:0]  es;
        sz = size_of(w);
        ed = exp_data(d, sz);
        es = exp_strb(a, sz);
        aw_done = 0;
        w_done = 0;
        chk("ready_idle", st_ready_o, 1);
        st_valid = 1; st_addr = a; st_data = d; st_width = w;
        step();
        st_valid = 0; st_addr = $urandom; st_data = $urandom; st_width = 2'($urandom);
        if (a % sz != 0) begin
            chk("mis_awvalid", awvalid_o, 0);
            chk("mis_wvalid", wvalid_o, 0);
            chk("mis_err", st_err_o, 1);
            chk("mis_typ", st_err_typ_o, 0);
            chk("mis_addr", st_err_addr_o, a);
            chk("mis_ready", st_ready_o, 1);
            chk("mis_bp", bp_o, 0);
            step();
            chk("mis_pulse", st_err_o, 0);
            chk("mis_awvalid2", awvalid_o, 0);
            return;
        end
        chk("acc_bp", bp_o, 1);
        chk("acc_ready", st_ready_o, 0);
        cyc = 0;
        while (!(aw_done && w_done)) begin
            if (cyc > 60) begin
                chk("timeout_aw_w", 0, 1);
                break;
            end
            chk("awvalid", awvalid_o, !aw_done);
            chk("wvalid", wvalid_o, !w_done);
            chk("bready_early", bready_o, 0);
            chk("err_quiet", st_err_o, 0);
            chk("bp_addr", bp_o, 1);
            if (!aw_done) chk("awaddr", awaddr_o, a);
            if (!w_done) begin
                chk("wdata", wdata_o, ed);
                chk("wstrb", wstrb_o, es);
            end
            awready = aw_done ? 1'($urandom) : (cyc >= awd);
            wready  = w_done ? 1'($urandom) : (cyc >= wd);
            bvalid  = 1'($urandom);
            bresp   = 2'b10;
            hs_aw = awvalid_o && awready;
            hs_w  = wvalid_o && wready;
            step();
            if (hs_aw) aw_done = 1;
            if (hs_w) w_done = 1;
            cyc++;
        end
        awready = 0; wready = 0; bvalid = 0;
        cyc = 0;
        forever begin
            if (cyc > 60) begin
                chk("timeout_b", 0, 1);
                break;
            end
            chk("bready", bready_o, 1);
            chk("aw_low", awvalid_o, 0);
            chk("w_low", wvalid_o, 0);
            chk("bp_resp", bp_o, 1);
            bvalid = cyc >= bd;
            bresp = bvalid ? resp : 2'($urandom);
            step();
            if (bvalid) break;
            cyc++;
        end
        bvalid = 0;
        chk("done_bready", bready_o, 0);
        chk("done_ready", st_ready_o, 1);
        chk("done_bp", bp_o, 0);
        chk("done_err", st_err_o, resp[1]);
        if (resp[1]) begin
            chk("berr_typ", st_err_typ_o, 1);
            chk("berr_addr", st_err_addr_o, a);
        end
    endtask

    task automatic reset_in(input bit in_resp);
        st_valid = 1; st_addr = 32'h0000_6000; st_data = $urandom; st_width = 2'd2;
        step();
        st_valid = 0;
        awready = in_resp; wready = in_resp;
        step();
        awready = 0; wready = 0;
        chk("pre_rst_bp", bp_o, 1);
        chk("pre_rst_bready", bready_o, in_resp);
        #2 rst = 1;
        #1;
        chk("rst_awvalid", awvalid_o, 0);
        chk("rst_wvalid", wvalid_o, 0);
        chk("rst_bready", bready_o, 0);
        chk("rst_ready", st_ready_o, 1);
        chk("rst_bp", bp_o, 0);
        step();
        rst = 0;
        step();
    endtask

    initial begin
        rst = 1; st_valid = 1; st_addr = 32'h100; st_data = 32'h1234; st_width = 2'd2;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        #1;
        chk("r_ready", st_ready_o, 1);
        chk("r_bp", bp_o, 0);
        chk("r_awvalid", awvalid_o, 0);
        chk("r_wvalid", wvalid_o, 0);
        chk("r_bready", bready_o, 0);
        chk("r_err", st_err_o, 0);
        chk("r_awaddr", awaddr_o, 0);
        chk("r_wdata", wdata_o, 0);
        chk("r_wstrb", wstrb_o, 0);
        chk("r_eaddr", st_err_addr_o, 0);
        step();
        step();
        chk("r_ignore", bp_o, 0);
        st_valid = 0;
        rst = 0;
        step();
        do_store(32'h1003, 32'hAABBCCDD, 2'd0, 0, 0, 0, 2'b00);
        do_store(32'h2002, 32'h12345678, 2'd1, 0, 0, 0, 2'b00);
        do_store(32'h2001, 32'h12345678, 2'd1, 0, 0, 0, 2'b00);
        do_store(32'h3001, 32'hDEADBEEF, 2'd2, 0, 0, 0, 2'b00);
        do_store(32'h4000, 32'hCAFEF00D, 2'd2, 3, 0, 0, 2'b00);
        do_store(32'h5000, 32'h0BADF00D, 2'd2, 0, 0, 1, 2'b10);
        do_store(32'h5004, 32'h11223344, 2'd3, 0, 2, 0, 2'b11);
        reset_in(1);
        do_store(32'h0, 32'h000000A5, 2'd0, 0, 0, 0, 2'b00);
        reset_in(0);
        do_store(32'h0, 32'h0000005A, 2'd0, 1, 1, 0, 2'b00);
        for (int i = 0; i < 200; i++)
            do_store($urandom, $urandom, 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), 2'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
